// File: rtl/rr_arbiter_2pn_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side drives requests and the release strobe.
// The slave side is the arbiter, which returns the registered grant.
interface rr_arbiter_2pn_if #(
   parameter int N = 5
);
   localparam int NUM = 1 << N;

   logic [NUM-1:0] req;
   logic           done;
   logic [NUM-1:0] gnt;
   logic [N-1:0]   gnt_idx;
   logic           gnt_vld;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_idx,
      input  gnt_vld
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_idx,
      output gnt_vld
   );
endinterface

// File: rtl/rr_arbiter_2pn.sv
// Round-robin arbiter for 2**N requesters with a hold-until-release handshake.
// The grant is registered as a one-hot vector, a binary index and a valid flag.
// The owner keeps the resource until it pulses done, drops its request, or hits
// the optional MAX_HOLD timeout. Each release is followed by one idle cycle
// before the next arbitration.
module rr_arbiter_2pn #(
   parameter int N        = 5,
   parameter int MAX_HOLD = 0,
   parameter int HOLD_W   = 16
) (
   input logic              clk,
   input logic              rst,
   rr_arbiter_2pn_if.slave  bus
);
   localparam int NUM = 1 << N;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t            state;
   logic [N-1:0]      ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic [N-1:0]      sel;
   logic              sel_found;
   logic [N-1:0]      cand;
   logic              timeout_hit;
   logic              release_now;

   // Pick the first active request, scanning upward from ptr and wrapping.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM; i++) begin
         cand = ptr + N'(i);
         if (!sel_found && bus.req[cand]) begin
            sel       = cand;
            sel_found = 1'b1;
         end
      end
   end

   // The owner gives up the resource on done, on dropping its request, or on timeout.
   always_comb begin
      timeout_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));
      release_now = bus.done || !bus.req[bus.gnt_idx] || timeout_hit;
   end

   // FSM with registered outputs. gnt_idx is left at its last value across the idle
   // cycle, and ptr moves past the released owner so that it competes last next time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         hold_cnt    <= '0;
         bus.gnt     <= '0;
         bus.gnt_idx <= '0;
         bus.gnt_vld <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sel_found) begin
                  state       <= ST_GRANT;
                  bus.gnt     <= {{(NUM-1){1'b0}}, 1'b1} << sel;
                  bus.gnt_idx <= sel;
                  bus.gnt_vld <= 1'b1;
                  hold_cnt    <= HOLD_W'(1);
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  state       <= ST_IDLE;
                  bus.gnt     <= '0;
                  bus.gnt_vld <= 1'b0;
                  ptr         <= bus.gnt_idx + N'(1);
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rr_arbiter_2pn.sv
// Directed testbench for rr_arbiter_2pn.
// dut_a uses an unlimited hold time; dut_b uses MAX_HOLD=4 to exercise the timeout.
module tb_rr_arbiter_2pn;
   localparam int N = 5;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   pass_count;
   int   total_count;

   rr_arbiter_2pn_if #(.N(N)) bus_a ();
   rr_arbiter_2pn_if #(.N(N)) bus_b ();

   rr_arbiter_2pn #(.N(N), .MAX_HOLD(0), .HOLD_W(16)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a.slave)
   );

   rr_arbiter_2pn #(.N(N), .MAX_HOLD(4), .HOLD_W(16)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b.slave)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Step one rising edge, then wait 1 unit so that the outputs are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic check_a(input string tag, input logic vld, input logic [31:0] idx,
                          input logic [31:0] gnt);
      check_output({tag, ".vld"}, {31'b0, bus_a.gnt_vld}, {31'b0, vld});
      check_output({tag, ".idx"}, {27'b0, bus_a.gnt_idx}, idx);
      check_output({tag, ".gnt"}, bus_a.gnt, gnt);
   endtask

   // Directed sequence: each step drives inputs, advances one edge, and checks the result.
   initial begin
      logic [31:0] one_hot;
      int          k;

      pass_count  = 0;
      total_count = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.req  = '0;
      bus_a.done = 1'b0;
      bus_b.req  = '0;
      bus_b.done = 1'b0;
      tick();
      tick();
      check_a("reset", 1'b0, 0, 32'h0);
      rst_a = 1'b0;

      // Single request: grant to index 3, hold, release on done.
      $display("[TB] single request");
      bus_a.req = 32'h0000_0008;
      tick();
      check_a("single.grant", 1'b1, 3, 32'h8);
      tick();
      check_a("single.hold", 1'b1, 3, 32'h8);
      bus_a.done = 1'b1;
      tick();
      check_a("single.release", 1'b0, 3, 32'h0);
      bus_a.done = 1'b0;
      bus_a.req  = 32'h0000_001C;
      tick();
      check_a("single.ptr4", 1'b1, 4, 32'h10);
      bus_a.req = '0;
      tick();
      check_a("single.drop", 1'b0, 4, 32'h0);

      // Round-robin sweep from ptr=0 with all requests held high.
      $display("[TB] round-robin sweep");
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      bus_a.req = 32'hFFFF_FFFF;
      for (int s = 0; s < 34; s++) begin
         k = s % 32;
         one_hot = 32'h1 << k;
         tick();
         check_a($sformatf("sweep%0d.grant", s), 1'b1, k, one_hot);
         bus_a.done = 1'b1;
         tick();
         check_output($sformatf("sweep%0d.dead", s), {31'b0, bus_a.gnt_vld}, 32'h0);
         bus_a.done = 1'b0;
      end

      // Wrap-around: grant index 30 so that ptr becomes 31, then compete bits 0 and 5.
      $display("[TB] wrap-around");
      bus_a.req = 32'h4000_0000;
      tick();
      check_a("wrap.g30", 1'b1, 30, 32'h4000_0000);
      bus_a.done = 1'b1;
      tick();
      bus_a.done = 1'b0;
      bus_a.req  = 32'h0000_0021;
      tick();
      check_a("wrap.g0", 1'b1, 0, 32'h1);
      bus_a.done = 1'b1;
      tick();
      check_a("wrap.rel0", 1'b0, 0, 32'h0);
      bus_a.done = 1'b0;
      tick();
      check_a("wrap.g5", 1'b1, 5, 32'h20);
      bus_a.done = 1'b1;
      tick();
      bus_a.done = 1'b0;

      // Request drop: owner 9 withdraws, and 12 beats 2 because ptr is now 10.
      $display("[TB] request drop");
      bus_a.req = 32'h0000_0200;
      tick();
      check_a("drop.g9", 1'b1, 9, 32'h200);
      bus_a.req = 32'h0000_1004;
      tick();
      check_a("drop.rel", 1'b0, 9, 32'h0);
      tick();
      check_a("drop.g12", 1'b1, 12, 32'h1000);
      bus_a.req = 32'h0000_100C;
      tick();
      check_a("drop.lowprio_ignored", 1'b1, 12, 32'h1000);
      bus_a.done = 1'b1;
      tick();
      check_a("drop.rel12", 1'b0, 12, 32'h0);

      // done while idle is ignored.
      bus_a.req = '0;
      tick();
      check_a("idle_done", 1'b0, 12, 32'h0);
      bus_a.done = 1'b0;

      // Reset mid-grant clears everything, including ptr.
      $display("[TB] reset mid-grant");
      bus_a.req = 32'h0002_0000;
      tick();
      check_a("rstmid.g17", 1'b1, 17, 32'h0002_0000);
      rst_a = 1'b1;
      tick();
      check_a("rstmid.cleared", 1'b0, 0, 32'h0);
      rst_a = 1'b0;
      bus_a.req = 32'hFFFF_FFFF;
      tick();
      check_a("rstmid.g0", 1'b1, 0, 32'h1);

      // Timeout on dut_b: the sole requester 7 is granted for 4 cycles, then idle for 1.
      $display("[TB] timeout");
      tick();
      rst_b = 1'b0;
      bus_b.req = 32'h0000_0080;
      for (int t = 0; t < 15; t++) begin
         tick();
         check_output($sformatf("timeout%0d.vld", t), {31'b0, bus_b.gnt_vld},
                      ((t % 5) != 4) ? 32'h1 : 32'h0);
         check_output($sformatf("timeout%0d.idx", t), {27'b0, bus_b.gnt_idx}, 32'd7);
         check_output($sformatf("timeout%0d.gnt", t), bus_b.gnt,
                      ((t % 5) != 4) ? 32'h80 : 32'h0);
      end

      $display("[TB] %0d/%0d checks passed", pass_count, total_count);
      $finish;
   end
endmodule
